// File: rtl/counter_seq_ctrl_if.sv
// Command/status bundle between the sequencing controller and the counter wrapper.
// The slave side is the controller; the master side drives commands and the counter value.
interface counter_seq_ctrl_if #(
   parameter int WIDTH = 4,
   parameter int PSC_W = 4
);
   logic             start;
   logic             stop;
   logic             mode_auto;
   logic [WIDTH-1:0] terminal;
   logic [PSC_W-1:0] psc;
   logic [WIDTH-1:0] cnt_val;
   logic             cnt_en;
   logic             cnt_clr;
   logic             busy;
   logic             done;
   logic [3:0]       reloads;

   modport master (
      output start, stop, mode_auto, terminal, psc, cnt_val,
      input  cnt_en, cnt_clr, busy, done, reloads
   );

   modport slave (
      input  start, stop, mode_auto, terminal, psc, cnt_val,
      output cnt_en, cnt_clr, busy, done, reloads
   );
endinterface

// File: rtl/counter_seq_ctrl.sv
// Start/stop sequencer for the enable-counter datapath: prescaled count ticks,
// terminal compare, one-shot or auto-reload with a saturating reload count.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; config latched on leaving
// CLEAR | one cycle, counter cleared
// RUN   | prescaler running; tick enables or clears the counter
// DONE  | one-cycle completion pulse in one-shot mode
module counter_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int PSC_W = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   counter_seq_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           state;
   logic [PSC_W-1:0] presc;
   logic [PSC_W-1:0] psc_l;
   logic [WIDTH-1:0] term_l;
   logic             mode_l;
   logic [3:0]       reloads_q;

   logic tick;
   logic at_tc;

   assign tick  = (state == S_RUN) && (presc == psc_l);
   assign at_tc = (bus.cnt_val == term_l);

   // Outputs depend only on registered state and the counter value, never on start/stop.
   assign bus.cnt_clr = (state == S_CLEAR) | (tick & at_tc & mode_l);
   assign bus.cnt_en  = tick & ~at_tc;
   assign bus.busy    = (state == S_CLEAR) | (state == S_RUN);
   assign bus.done    = (state == S_DONE);
   assign bus.reloads = reloads_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         presc     <= '0;
         psc_l     <= '0;
         term_l    <= '0;
         mode_l    <= 1'b0;
         reloads_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!bus.stop && bus.start) begin
                  state     <= S_CLEAR;
                  term_l    <= bus.terminal;
                  psc_l     <= bus.psc;
                  mode_l    <= bus.mode_auto;
                  reloads_q <= '0;
               end
            end
            S_CLEAR: begin
               if (bus.stop) begin
                  state <= S_IDLE;
               end else begin
                  state <= S_RUN;
                  presc <= '0;
               end
            end
            S_RUN: begin
               if (bus.stop) begin
                  state <= S_IDLE;
               end else if (tick && at_tc && !mode_l) begin
                  state <= S_DONE;
               end else if (tick) begin
                  presc <= '0;
                  if (at_tc && mode_l && (reloads_q != 4'hf))
                     reloads_q <= reloads_q + 4'd1;
               end else begin
                  presc <= presc + 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a behavioural 4-bit counter datapath.
module tb_counter_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] cnt_q;

   counter_seq_ctrl_if #(.WIDTH(4), .PSC_W(4)) bus ();

   counter_seq_ctrl #(.WIDTH(4), .PSC_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Counter datapath: clear has priority over enable.
   always @(posedge clk) begin
      if (!rst_n)           cnt_q <= 4'd0;
      else if (bus.cnt_clr) cnt_q <= 4'd0;
      else if (bus.cnt_en)  cnt_q <= cnt_q + 4'd1;
   end
   assign bus.cnt_val = cnt_q;

   typedef struct {
      logic       r;
      logic       s;
      logic       p;
      logic       m;
      logic [3:0] t;
      logic [3:0] ps;
      logic [11:0] exp;   // {cnt_en, cnt_clr, busy, done, cnt_val, reloads}
   } vec_t;

   vec_t vecs[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   function automatic void v(input logic r, s, p, m, input logic [3:0] t, ps,
                             input logic e, c, b, d, input logic [3:0] cv, rl);
      vec_t x;
      x.r = r; x.s = s; x.p = p; x.m = m; x.t = t; x.ps = ps;
      x.exp = {e, c, b, d, cv, rl};
      vecs.push_back(x);
   endfunction

   task automatic cyc(input logic r, s, p, m, input logic [3:0] t, ps);
      @(negedge clk);
      rst_n = r; bus.start = s; bus.stop = p; bus.mode_auto = m;
      bus.terminal = t; bus.psc = ps;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [11:0] exp);
      logic [11:0] act;
      act = {bus.cnt_en, bus.cnt_clr, bus.busy, bus.done, cnt_q, bus.reloads};
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got en=%b clr=%b busy=%b done=%b cnt=%0d rel=%0d, want en=%b clr=%b busy=%b done=%b cnt=%0d rel=%0d",
                  name, act[11], act[10], act[9], act[8], act[7:4], act[3:0],
                  exp[11], exp[10], exp[9], exp[8], exp[7:4], exp[3:0]);
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.stop = 1'b0; bus.mode_auto = 1'b0;
      bus.terminal = 4'd0; bus.psc = 4'd0;

      // T1: psc=0, terminal=5, one-shot
      v(0,0,0,0,5,0, 0,0,0,0,0,0);
      v(1,1,0,0,5,0, 0,1,1,0,0,0);
      for (int k = 0; k < 5; k++) v(1,0,0,0,5,0, 1,0,1,0,4'(k),0);
      v(1,0,0,0,5,0, 0,0,1,0,5,0);
      v(1,0,0,0,5,0, 0,0,0,1,5,0);
      v(1,0,0,0,5,0, 0,0,0,0,5,0);
      // T2: psc=2, terminal=3, one-shot
      v(1,1,0,0,3,2, 0,1,1,0,5,0);
      for (int k = 0; k < 3; k++) begin
         v(1,0,0,0,3,2, 0,0,1,0,4'(k),0);
         v(1,0,0,0,3,2, 0,0,1,0,4'(k),0);
         v(1,0,0,0,3,2, 1,0,1,0,4'(k),0);
      end
      for (int k = 0; k < 3; k++) v(1,0,0,0,3,2, 0,0,1,0,3,0);
      v(1,0,0,0,3,2, 0,0,0,1,3,0);
      v(1,0,0,0,3,2, 0,0,0,0,3,0);
      // T4: stop lands with counter at 4; start+stop in IDLE
      v(1,1,0,0,9,0, 0,1,1,0,3,0);
      for (int k = 0; k < 4; k++) v(1,0,0,0,9,0, 1,0,1,0,4'(k),0);
      v(1,0,1,0,9,0, 0,0,0,0,4,0);
      v(1,0,0,0,9,0, 0,0,0,0,4,0);
      v(1,1,1,0,9,0, 0,0,0,0,4,0);
      v(1,0,0,0,9,0, 0,0,0,0,4,0);
      // T5a: terminal=0 one-shot
      v(1,1,0,0,0,0, 0,1,1,0,4,0);
      v(1,0,0,0,0,0, 0,0,1,0,0,0);
      v(1,0,0,0,0,0, 0,0,0,1,0,0);
      v(1,0,0,0,0,0, 0,0,0,0,0,0);
      // T5b: terminal=0 auto, psc=1; stop keeps reloads
      v(1,1,0,1,0,1, 0,1,1,0,0,0);
      v(1,0,0,1,0,1, 0,0,1,0,0,0);
      v(1,0,0,1,0,1, 0,1,1,0,0,0);
      v(1,0,0,1,0,1, 0,0,1,0,0,1);
      v(1,0,0,1,0,1, 0,1,1,0,0,1);
      v(1,0,0,1,0,1, 0,0,1,0,0,2);
      v(1,0,1,1,0,1, 0,0,0,0,0,2);
      v(1,0,0,1,0,1, 0,0,0,0,0,2);
      // T6: reset mid-run, psc=3, then normal restart
      v(1,1,0,0,9,3, 0,1,1,0,0,0);
      for (int k = 0; k < 3; k++) v(1,0,0,0,9,3, 0,0,1,0,0,0);
      v(1,0,0,0,9,3, 1,0,1,0,0,0);
      v(1,0,0,0,9,3, 0,0,1,0,1,0);
      v(1,0,0,0,9,3, 0,0,1,0,1,0);
      v(0,0,0,0,9,3, 0,0,0,0,0,0);
      v(1,0,0,0,9,3, 0,0,0,0,0,0);
      v(1,1,0,0,9,3, 0,1,1,0,0,0);
      for (int k = 0; k < 3; k++) v(1,0,0,0,9,3, 0,0,1,0,0,0);
      v(1,0,0,0,9,3, 1,0,1,0,0,0);
      v(1,0,0,0,9,3, 0,0,1,0,1,0);
      v(1,0,1,0,9,3, 0,0,0,0,1,0);
      // T7: start held high, terminal=1: new run one cycle after DONE
      v(1,1,0,0,1,0, 0,1,1,0,1,0);
      v(1,1,0,0,1,0, 1,0,1,0,0,0);
      v(1,1,0,0,1,0, 0,0,1,0,1,0);
      v(1,1,0,0,1,0, 0,0,0,1,1,0);
      v(1,1,0,0,1,0, 0,0,0,0,1,0);
      v(1,1,0,0,1,0, 0,1,1,0,1,0);
      v(1,1,0,0,1,0, 1,0,1,0,0,0);
      v(1,1,1,0,1,0, 0,0,0,0,1,0);
      v(1,0,0,0,1,0, 0,0,0,0,1,0);

      foreach (vecs[i]) begin
         cyc(vecs[i].r, vecs[i].s, vecs[i].p, vecs[i].m, vecs[i].t, vecs[i].ps);
         chk($sformatf("vec%0d", i), vecs[i].exp);
      end

      // T3: psc=0, terminal=2, auto; reloads saturates after 15 wraps
      cyc(1,1,0,1,2,0);
      chk("auto_clear", {1'b0,1'b1,1'b1,1'b0,4'd1,4'd0});
      for (int i = 0; i < 66; i++) begin
         logic       at;
         logic [3:0] rl;
         at = ((i % 3) == 2);
         rl = ((i / 3) > 15) ? 4'd15 : 4'(i / 3);
         cyc(1,0,0,1,2,0);
         chk($sformatf("auto_run%0d", i), {~at, at, 1'b1, 1'b0, 4'(i % 3), rl});
      end
      cyc(1,0,1,1,2,0);
      chk("auto_stop", {1'b0,1'b0,1'b0,1'b0,4'd0,4'd15});
      cyc(1,0,0,1,2,0);
      chk("auto_idle", {1'b0,1'b0,1'b0,1'b0,4'd0,4'd15});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
